// File: rtl/dmem_avalon_bridge.sv
// Data-memory responder: turns MMIX byte/wyde/tetra/octa requests into one or two
// big-endian 32-bit Avalon-MM beats.
module dmem_avalon_bridge #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [63:0]           mem_address,
    input  logic [1:0]            mem_datasize,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [63:0]           mem_writedata,
    output logic [63:0]           mem_readdata,
    output logic                  mem_done,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [3:0]            avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid
);

    typedef enum logic [1:0] {StIdle, StCmd, StRdata, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [63:0]           wdata_q;
    logic                  is_read_q;
    logic                  beat_q, beat_d;
    logic [31:0]           hi_q, hi_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  start;
    logic                  is_octa;
    logic [3:0]            lane_be;
    logic [31:0]           byte_shift;
    logic [31:0]           lane_data;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^mem_address[63:ADDR_WIDTH];
    assign start          = (state_q == StIdle) && (mem_read || mem_write);
    assign is_octa        = (size_q == 2'd3);
    assign mem_readdata   = rdata_q;
    assign mem_done       = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) state_d = StCmd;
            end
            StCmd: begin
                if (!avm_waitrequest) begin
                    if (is_read_q)              state_d = StRdata;
                    else if (is_octa && !beat_q) state_d = StCmd;
                    else                        state_d = StDone;
                end
            end
            StRdata: begin
                if (avm_readdatavalid) state_d = (is_octa && !beat_q) ? StCmd : StDone;
            end
            // Request inputs are still asserted here and must not start a new access.
            StDone: state_d = StIdle;
        endcase
    end

    always_comb begin
        lane_be       = 4'b1111;
        avm_address   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        avm_writedata = wdata_q[31:0];
        byte_shift    = avm_readdata >> {~addr_q[1:0], 3'b000};
        lane_data     = avm_readdata;
        unique case (size_q)
            2'd0: begin
                lane_be       = 4'b1000 >> addr_q[1:0];
                avm_writedata = {4{wdata_q[7:0]}};
                lane_data     = {24'h0, byte_shift[7:0]};
            end
            2'd1: begin
                lane_be       = addr_q[1] ? 4'b0011 : 4'b1100;
                avm_writedata = {2{wdata_q[15:0]}};
                lane_data     = {16'h0, addr_q[1] ? avm_readdata[15:0] : avm_readdata[31:16]};
            end
            2'd2: begin
                lane_be = 4'b1111;
            end
            2'd3: begin
                avm_address   = {addr_q[ADDR_WIDTH-1:3], beat_q, 2'b00};
                avm_writedata = beat_q ? wdata_q[31:0] : wdata_q[63:32];
            end
        endcase

        avm_read       = (state_q == StCmd) && is_read_q;
        avm_write      = (state_q == StCmd) && !is_read_q;
        avm_byteenable = (state_q == StCmd) ? lane_be : 4'b0000;

        beat_d  = beat_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        if (start) beat_d = 1'b0;
        if (state_q == StCmd && !avm_waitrequest && !is_read_q && is_octa && !beat_q) begin
            beat_d = 1'b1;
        end
        // Octa beat 0 is staged so mem_readdata only changes when the whole load completes.
        if (state_q == StRdata && avm_readdatavalid) begin
            if (is_octa && !beat_q) begin
                hi_d   = avm_readdata;
                beat_d = 1'b1;
            end else begin
                rdata_d = is_octa ? {hi_q, avm_readdata} : {32'h0, lane_data};
            end
        end
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            size_q    <= 2'd0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            beat_q    <= 1'b0;
            hi_q      <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            if (start) begin
                addr_q    <= mem_address[ADDR_WIDTH-1:0];
                size_q    <= mem_datasize;
                wdata_q   <= mem_writedata;
                is_read_q <= mem_read;
            end
            beat_q  <= beat_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_dmem_avalon_bridge.sv
// Bench for dmem_avalon_bridge: directed vector table, hand sequences for stall/CSWAP/reset,
// and randomized traffic against a byte-level memory model and an Avalon responder.
module tb_dmem_avalon_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] mem_address = '0;
    logic [1:0]  mem_datasize = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] mem_writedata = '0;
    logic [63:0] mem_readdata;
    logic        mem_done;
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    dmem_avalon_bridge #(.ADDR_WIDTH(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_address       (mem_address),
        .mem_datasize      (mem_datasize),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata),
        .mem_done          (mem_done),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } beat_t;

    typedef struct {
        logic        rd;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic [31:0] exp_a0;
        logic [3:0]  exp_be0;
        logic [31:0] exp_wd0;
        int          exp_lat;
    } vec_t;

    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [31:0] smem[int unsigned];
    logic [7:0]  mbytes[int unsigned];
    logic [63:0] model_val;
    logic [63:0] last_rd = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          stall_pct = 0;
    int          rd_delay_min = 0;
    int          max_rd_delay = 0;
    int          force_stall = 0;
    logic        both_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] w);
        return (w * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : pattern(a);
    endfunction

    // Model memory is byte-addressed; byte k of a tetra sits in bits [8*(3-k) +: 8].
    function automatic logic [7:0] model_byte(input logic [31:0] a);
        logic [31:0] w;
        int          sh;
        if (mbytes.exists(a)) return mbytes[a];
        w  = pattern({a[31:2], 2'b00});
        sh = 8 * (3 - int'(a[1:0]));
        return w[sh +: 8];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        smem[a] = w;
        for (int i = 0; i < 4; i++) mbytes[a + 32'(i)] = w[(3 - i) * 8 +: 8];
    endtask

    task automatic model_request(input logic rd, input logic [1:0] size, input logic [63:0] addr64,
                                 input logic [63:0] wd);
        int          n;
        int          ngroups;
        int          j;
        logic [31:0] base;
        logic [31:0] gaddr;
        logic [31:0] a;
        beat_t       e;
        n       = 1 << size;
        base    = addr64[31:0] & ~32'(n - 1);
        ngroups = (n == 8) ? 2 : 1;
        exp_q.delete();
        for (int b = 0; b < ngroups; b++) begin
            gaddr = (base & ~32'h3) + 32'(4 * b);
            e.wr  = !rd;
            e.addr = gaddr;
            e.be  = '0;
            e.wd  = '0;
            for (int k = 0; k < n; k++) begin
                a = base + 32'(k);
                if ((a & ~32'h3) == gaddr) e.be[3 - int'(a[1:0])] = 1'b1;
            end
            for (int lane = 0; lane < 4; lane++) begin
                j = (n == 8) ? (b * 4 + (3 - lane)) : ((3 - lane) % n);
                e.wd[lane * 8 +: 8] = wd[(n - 1 - j) * 8 +: 8];
            end
            exp_q.push_back(e);
        end
        model_val = '0;
        for (int k = 0; k < n; k++) begin
            if (rd) model_val = (model_val << 8) | 64'(model_byte(base + 32'(k)));
            else    mbytes[base + 32'(k)] = wd[(n - 1 - k) * 8 +: 8];
        end
    endtask

    task automatic do_req(input logic rd, input logic [1:0] size, input logic [63:0] addr,
                          input logic [63:0] wd, output logic [63:0] rdata, output int lat);
        @(posedge clk);
        #1;
        mem_read      = rd;
        mem_write     = !rd || both_req;
        mem_address   = addr;
        mem_datasize  = size;
        mem_writedata = wd;
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mem_done) begin
                lat = c;
                break;
            end
        end
        rdata = mem_readdata;
    endtask

    task automatic run_and_check(input string tag, input logic rd, input logic [1:0] size,
                                 input logic [63:0] addr, input logic [63:0] wd,
                                 output logic [63:0] rdata, output int lat);
        logic [63:0] exp_rd;
        model_request(rd, size, addr, wd);
        exp_rd = rd ? model_val : last_rd;
        last_rd = exp_rd;
        got_q.delete();
        do_req(rd, size, addr, wd, rdata, lat);
        check({tag, " done_seen"}, 64'(lat >= 0), 64'd1);
        check({tag, " rdata"}, rdata, exp_rd);
        check({tag, " nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s beat%0d ctl", tag, i), {got_q[i].wr, got_q[i].addr, got_q[i].be},
                  {exp_q[i].wr, exp_q[i].addr, exp_q[i].be});
            if (exp_q[i].wr) check($sformatf("%s beat%0d wdata", tag, i), 64'(got_q[i].wd),
                                   64'(exp_q[i].wd));
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("done_single", 64'(mem_done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_done"}, 64'(mem_done), 64'd0);
        check({tag, " mem_readdata"}, mem_readdata, 64'd0);
        check({tag, " avm_cmd"}, {avm_read, avm_write, avm_byteenable}, 64'd0);
        check({tag, " avm_address"}, 64'(avm_address), 64'd0);
        check({tag, " avm_writedata"}, 64'(avm_writedata), 64'd0);
    endtask

    // Avalon responder: logs accepted beats, stalls on request, returns read data after a delay.
    logic        prev_stall = 1'b0;
    logic [37:0] prev_ctl;
    logic [31:0] prev_wd;
    logic        rd_pending = 1'b0;
    int          rd_wait = 0;
    logic [31:0] rd_word;

    initial begin
        logic  cmd;
        beat_t b;
        logic [31:0] w;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_pending        = 1'b0;
                prev_stall        = 1'b0;
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = 1'b0;
            end else begin
                cmd = avm_read | avm_write;
                if (prev_stall) begin
                    check("hold ctl", 64'({avm_read, avm_write, avm_byteenable, avm_address}),
                          64'(prev_ctl));
                    check("hold wdata", 64'(avm_writedata), 64'(prev_wd));
                end
                prev_stall = cmd && avm_waitrequest;
                prev_ctl   = {avm_read, avm_write, avm_byteenable, avm_address};
                prev_wd    = avm_writedata;
                if (cmd && !avm_waitrequest) begin
                    b.wr = avm_write;
                    b.addr = avm_address;
                    b.be = avm_byteenable;
                    b.wd = avm_writedata;
                    got_q.push_back(b);
                    w = slave_word(avm_address);
                    if (avm_write) begin
                        for (int l = 0; l < 4; l++)
                            if (avm_byteenable[l]) w[l * 8 +: 8] = avm_writedata[l * 8 +: 8];
                        smem[avm_address] = w;
                    end else begin
                        rd_pending = 1'b1;
                        rd_wait    = int'($urandom_range(rd_delay_min, max_rd_delay));
                        rd_word    = w;
                    end
                end
                @(posedge clk);
                #1;
                avm_readdatavalid = 1'b0;
                avm_readdata      = $urandom;
                if (rd_pending) begin
                    if (rd_wait == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = rd_word;
                        rd_pending        = 1'b0;
                    end else begin
                        rd_wait--;
                    end
                end
                cmd = avm_read | avm_write;
                if (cmd && force_stall > 0) begin
                    avm_waitrequest = 1'b1;
                    force_stall--;
                end else begin
                    avm_waitrequest = cmd && ($urandom_range(0, 99) < stall_pct);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[12];
        logic [63:0] r;
        int          lat;
        beat_t       first;
        logic        rrd;
        logic [1:0]  rsz;
        logic [63:0] raddr;
        logic [63:0] rwd;

        tbl[0]  = '{1'b0, 2'd0, 64'h1005, 64'hAB, 64'h0, 32'h1004, 4'b0100, 32'hABABABAB, 2};
        tbl[1]  = '{1'b1, 2'd1, 64'h2003, 64'h0, 64'h5678, 32'h2000, 4'b0011, 32'h0, 3};
        tbl[2]  = '{1'b1, 2'd3, 64'h3007, 64'h0, 64'hDEADBEEF_01234567, 32'h3000, 4'b1111,
                    32'h0, 5};
        tbl[3]  = '{1'b1, 2'd0, 64'h1005, 64'h0, 64'hAB, 32'h1004, 4'b0100, 32'h0, 3};
        tbl[4]  = '{1'b0, 2'd1, 64'h1002, 64'hFFFF_CAFE, 64'hAB, 32'h1000, 4'b0011,
                    32'hCAFECAFE, 2};
        tbl[5]  = '{1'b1, 2'd2, 64'h1003, 64'h0, 64'h1122CAFE, 32'h1000, 4'b1111, 32'h0, 3};
        tbl[6]  = '{1'b1, 2'd2, 64'h1004, 64'h0, 64'h55AB7788, 32'h1004, 4'b1111, 32'h0, 3};
        tbl[7]  = '{1'b0, 2'd3, 64'h4000, 64'h01234567_89ABCDEF, 64'h55AB7788, 32'h4000,
                    4'b1111, 32'h01234567, 3};
        tbl[8]  = '{1'b1, 2'd3, 64'h4000, 64'h0, 64'h01234567_89ABCDEF, 32'h4000, 4'b1111,
                    32'h0, 5};
        tbl[9]  = '{1'b0, 2'd2, 64'h4006, 64'hFFFFFFFF_0BADF00D, 64'h01234567_89ABCDEF,
                    32'h4004, 4'b1111, 32'h0BADF00D, 2};
        tbl[10] = '{1'b1, 2'd1, 64'h4004, 64'h0, 64'h0BAD, 32'h4004, 4'b1100, 32'h0, 3};
        tbl[11] = '{1'b1, 2'd0, 64'h4007, 64'h0, 64'h0D, 32'h4004, 4'b0001, 32'h0, 3};

        preload(32'h2000, 32'h12345678);
        preload(32'h3000, 32'hDEADBEEF);
        preload(32'h3004, 32'h01234567);
        preload(32'h1000, 32'h11223344);
        preload(32'h1004, 32'h55667788);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("v%0d", i), tbl[i].rd, tbl[i].size, tbl[i].addr, tbl[i].wd,
                          r, lat);
            check($sformatf("v%0d table_rdata", i), r, tbl[i].exp_rd);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            first.addr = 'x;
            first.be   = 'x;
            first.wd   = 'x;
            if (got_q.size() > 0) first = got_q[0];
            check($sformatf("v%0d addr0", i), 64'(first.addr), 64'(tbl[i].exp_a0));
            check($sformatf("v%0d be0", i), 64'(first.be), 64'(tbl[i].exp_be0));
            if (!tbl[i].rd) check($sformatf("v%0d wd0", i), 64'(first.wd), 64'(tbl[i].exp_wd0));
            idle();
        end

        // Octa store with beat 0 stalled three cycles.
        force_stall = 3;
        run_and_check("sto_stall", 1'b0, 2'd3, 64'h4000, 64'hAAAABBBB_CCCCDDDD, r, lat);
        check("sto_stall latency", 64'(lat), 64'd6);
        idle();

        // Read wins when both request lines are high.
        both_req = 1'b1;
        run_and_check("both_req", 1'b1, 2'd2, 64'h4000, 64'h0, r, lat);
        both_req = 1'b0;
        idle();

        // CSWAP: read held through its done cycle, write presented in the following cycle.
        run_and_check("cswap_rd", 1'b1, 2'd2, 64'h4004, 64'h0, r, lat);
        run_and_check("cswap_wr", 1'b0, 2'd2, 64'h4004, 64'h13572468, r, lat);
        check("cswap_wr latency", 64'(lat), 64'd2);
        idle();
        run_and_check("cswap_chk", 1'b1, 2'd2, 64'h4004, 64'h0, r, lat);
        idle();

        // Reset while octa beat 0 read data is outstanding.
        rd_delay_min = 6;
        max_rd_delay = 6;
        got_q.delete();
        @(posedge clk);
        #1;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        mem_datasize = 2'd3;
        mem_address  = 64'h3000;
        repeat (3) @(negedge clk);
        check("rst_mid in_rdata", 64'({avm_read, avm_write, mem_done}), 64'd0);
        #2;
        reset_n  = 1'b0;
        mem_read = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset_n      = 1'b1;
        rd_delay_min = 0;
        max_rd_delay = 0;
        last_rd      = '0;
        run_and_check("post_rst_ldt", 1'b1, 2'd2, 64'h1000, 64'h0, r, lat);
        check("post_rst latency", 64'(lat), 64'd3);
        idle();

        // Randomized traffic in a small window so accesses overlap.
        stall_pct    = 30;
        max_rd_delay = 3;
        for (int i = 0; i < 150; i++) begin
            rrd   = 1'($urandom_range(0, 1));
            rsz   = 2'($urandom_range(0, 3));
            raddr = {$urandom, 32'h8000 + 32'($urandom_range(0, 255))};
            rwd   = {$urandom, $urandom};
            run_and_check($sformatf("rnd%0d", i), rrd, rsz, raddr, rwd, r, lat);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
